adder_serial_n: RTL
===================

ADDER_SERIAL_N -- requirements
Module: adder_serial_n

Interface
Parameters:
REQ-001 The block SHALL have parameter N, default 8: operand width in bits; N >= 1.
REQ-002 The block SHALL have parameter CHUNK, default 2: bits added per cycle; 1 <= CHUNK <= N; N SHALL be a multiple of CHUNK, and other values are unsupported.
Ports:
REQ-003 The block SHALL have clk  input  1: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have rst_n  input  1: synchronous reset, active-low.
REQ-005 The block SHALL have start  input  1: request to add; accepted only when ready=1.
REQ-006 The block SHALL have a, b  input  N each: operands, sampled only at acceptance.
REQ-007 The block SHALL have c_in  input  1: carry-in, sampled only at acceptance.
REQ-008 The block SHALL have ready  output  1: block is idle and can accept start.
REQ-009 The block SHALL have done  output  1: one-cycle pulse marking a new valid result.
REQ-010 The block SHALL have sum  output  N: registered result.
REQ-011 The block SHALL have c_out  output  1: registered carry-out of bit N-1.

Function
REQ-012 The block SHALL implement the FSM states IDLE, RUN and DONE; ready SHALL be 1 only in IDLE.
REQ-013 When IDLE and start=1, the block SHALL capture a, b and c_in into internal registers, clear the chunk counter k to 0 and enter RUN on the same edge.
REQ-014 In each RUN cycle, the block SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) of the captured operands plus the carry register, store the partial sum internally, update the carry register and increment k.
REQ-015 After chunk N/CHUNK-1, the block SHALL enter DONE, load sum and c_out from the internal result and assert done.
REQ-016 The block SHALL stay in DONE for exactly one cycle, then return to IDLE.
REQ-017 Latency: if start is accepted at edge T, done SHALL be 1 in the cycle after edge T+N/CHUNK, so that for N=8 and CHUNK=2, done is 1 for the single cycle after edge T+4.
REQ-018 sum and c_out SHALL change only on entry to DONE or on reset, and SHALL hold their value otherwise, including throughout the next RUN.
REQ-019 start SHALL be ignored in RUN and DONE, with no effect on the operation in progress.
REQ-020 Changes on a, b or c_in after acceptance SHALL have no effect on the result.
REQ-021 The result SHALL be exact modulo 2^N, with c_out equal to bit N of a+b+c_in.
REQ-022 When CHUNK=N, RUN SHALL last exactly one cycle.

Reset
REQ-023 When rst_n=0 at a clock edge, the block SHALL enter IDLE, clear k, clear the carry and internal registers, and set sum=0, c_out=0, done=0 and overflow=0 (when present); ready SHALL be 1 after that edge.
REQ-024 Reset asserted during RUN or DONE SHALL abort the operation, with no done pulse for the aborted request.
REQ-025 start presented in the same cycle as rst_n=0 SHALL be ignored.

Configuration
REQ-026 When the macro ADDER_SERIAL_OVERFLOW_EN is defined, the block SHALL add the port overflow  output  1, registered, which on entry to DONE SHALL take the value (carry into bit N-1) XOR (carry out of bit N-1), i.e. two's-complement overflow, and SHALL hold that value under the same rules as sum.
REQ-027 When ADDER_SERIAL_OVERFLOW_EN is not defined, the overflow port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 With N=8, CHUNK=2, a=8'hFF, b=8'h01, c_in=0 and start accepted at edge T, the bench SHALL check that done=1 only in the cycle after edge T+4, with sum=8'h00 and c_out=1.
REQ-029 With N=8, CHUNK=2, a=8'h7F, b=8'h01, c_in=0, the bench SHALL check sum=8'h80 and c_out=0; with the macro defined, it SHALL also check overflow=1.
REQ-030 With a=8'h00, b=8'h00, c_in=1, the bench SHALL check sum=8'h01 and c_out=0; it SHALL then start a=8'h12, b=8'h34 and check that sum holds 8'h01 through RUN and becomes 8'h46 at done.
REQ-031 With start held high throughout one operation (a=8'h0F, b=8'h01) while a and b change every cycle, the bench SHALL check a single done with sum=8'h10, ready=0 during RUN and DONE, and that a new acceptance occurs only in IDLE.
REQ-032 With rst_n=0 for one cycle, two cycles after acceptance, the bench SHALL check that the next cycle shows ready=1, done=0, sum=0 and c_out=0, and that no done pulse follows.
REQ-033 With N=8, CHUNK=8, a=8'hC8, b=8'h64, the bench SHALL check that done occurs in the cycle after edge T+1, with sum=8'h2C and c_out=1.

Source files
------------

// File: rtl/adder_serial_n_if.sv
// Operand/result bundle for adder_serial_n.
// The overflow signal exists only when ADDER_SERIAL_OVERFLOW_EN is defined.
interface adder_serial_n_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         ready;
    logic         done;
    logic [N-1:0] sum;
    logic         c_out;
`ifdef ADDER_SERIAL_OVERFLOW_EN
    logic         overflow;

    modport master (output start, a, b, c_in, input ready, done, sum, c_out, overflow);
    modport slave  (input start, a, b, c_in, output ready, done, sum, c_out, overflow);
`else
    modport master (output start, a, b, c_in, input ready, done, sum, c_out);
    modport slave  (input start, a, b, c_in, output ready, done, sum, c_out);
`endif
endinterface

// File: rtl/adder_serial_n.sv
// Multi-cycle adder processing CHUNK bits per cycle, least significant chunk first.
// Define ADDER_SERIAL_OVERFLOW_EN to add the registered two's-complement overflow output.
module adder_serial_n #(
    parameter int N     = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_serial_n_if.slave  bus
);

    localparam int NCHUNK = N / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [KW-1:0]  r_k;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic           r_carry;
    logic [N-1:0]   r_part;
    logic [N-1:0]   r_sum;
    logic           r_cout;
    logic           w_accept;
    logic           w_lastChunk;
    logic [CHUNK:0] w_chunkSum;
    logic [N-1:0]   w_chunkTop;
    logic [N-1:0]   w_partNext;
`ifdef ADDER_SERIAL_OVERFLOW_EN
    logic           r_ovf;
    logic           w_carryIntoMsb;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (w_lastChunk) begin
                    w_stateNext = DONE;
                end
            end
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Operands shift right so the active chunk is always at bit 0; results enter from the top.
    assign w_lastChunk = (r_k == K_LAST);
    assign w_chunkSum  = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + (CHUNK+1)'(r_carry);
    assign w_chunkTop  = N'(w_chunkSum[CHUNK-1:0]) << (N - CHUNK);
    assign w_partNext  = (r_part >> CHUNK) | w_chunkTop;
`ifdef ADDER_SERIAL_OVERFLOW_EN
    assign w_carryIntoMsb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_partNext[N-1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_part  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef ADDER_SERIAL_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_k     <= '0;
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.c_in;
            r_part  <= '0;
        end else if (r_state == RUN) begin
            r_k     <= r_k + 1'b1;
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_carry <= w_chunkSum[CHUNK];
            r_part  <= w_partNext;
            if (w_lastChunk) begin
                r_sum  <= w_partNext;
                r_cout <= w_chunkSum[CHUNK];
`ifdef ADDER_SERIAL_OVERFLOW_EN
                r_ovf  <= w_carryIntoMsb ^ w_chunkSum[CHUNK];
`endif
            end
        end
    end

    assign bus.ready = (r_state == IDLE);
    assign bus.done  = (r_state == DONE);
    assign bus.sum   = r_sum;
    assign bus.c_out = r_cout;
`ifdef ADDER_SERIAL_OVERFLOW_EN
    assign bus.overflow = r_ovf;
`endif

endmodule
